// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, aluop/alusel codes,
// multiplier FSM encoding and the operand magnitude helper.
package ex_stage_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 8;
    localparam int ALUSEL_W   = 3;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b00000000;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'b00100100;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'b00100101;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'b00100110;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'b00100111;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'b01111100;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'b00000010;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'b00000011;
    localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'b00010000;
    localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'b00010010;
    localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b00011001;

    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE  = 3'b011;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

    // Absolute value for signed operands; unsigned operands pass through.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [REG_W-1:0] magnitude(input logic [REG_W-1:0] v,
                                                  input logic signed_en);
        return (signed_en && v[REG_W-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Decode-side inputs and EX-side results of the execute stage.
// master = pipeline driver (ID/EX register), slave = ex_stage.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic [ALUOP_W-1:0]    aluop_i;
    logic [ALUSEL_W-1:0]   alusel_i;
    logic [REG_W-1:0]      reg1_i;
    logic [REG_W-1:0]      reg2_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;

    logic                  stallreq_o;
    logic                  ex_wreg_o;
    logic [REG_ADDR_W-1:0] ex_wd_o;
    logic [REG_W-1:0]      ex_wdata_o;
    logic                  mem_wreg_o;
    logic [REG_ADDR_W-1:0] mem_wd_o;
    logic [REG_W-1:0]      mem_wdata_o;
    logic [REG_W-1:0]      hi_o;
    logic [REG_W-1:0]      lo_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  stallreq_o, ex_wreg_o, ex_wd_o, ex_wdata_o,
               mem_wreg_o, mem_wd_o, mem_wdata_o, hi_o, lo_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        output stallreq_o, ex_wreg_o, ex_wd_o, ex_wdata_o,
               mem_wreg_o, mem_wd_o, mem_wdata_o, hi_o, lo_o
    );

endinterface

// File: rtl/ex_stage_mul_iter.sv
// Iterative 32-cycle shift-add multiplier with signed fix-up.
// IDLE -> BUSY (32 iterations) -> DONE (product valid for one unstalled cycle).
module mul_iter
    import ex_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_signed_en,
    input  logic [REG_W-1:0] i_a,
    input  logic [REG_W-1:0] i_b,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [63:0]      o_product
);

    mul_state_e       r_state;
    logic [4:0]       r_cnt;
    logic [REG_W-1:0] r_mcand;
    logic [REG_W-1:0] r_mplier;
    logic             r_neg;
    logic [63:0]      r_acc;
    logic             r_busy;
    logic             r_done;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= MUL_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_flush) begin
            r_state <= MUL_IDLE;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (!i_stall) begin
            case (r_state)
                MUL_IDLE: begin
                    if (i_start) begin
                        r_mcand  <= magnitude(i_a, i_signed_en);
                        r_mplier <= magnitude(i_b, i_signed_en);
                        r_neg    <= i_signed_en & (i_a[REG_W-1] ^ i_b[REG_W-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= MUL_BUSY;
                        r_busy   <= 1'b1;
                    end
                end
                MUL_BUSY: begin
                    if (r_mplier[r_cnt])
                        r_acc <= r_acc + ({32'd0, r_mcand} << r_cnt);
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= MUL_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                MUL_DONE: begin
                    r_state <= MUL_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= MUL_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_neg ? (64'd0 - r_acc) : r_acc;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: logic/shift/move ALU, same-cycle forward to decode,
// EX/MEM register, and HI/LO fed by the iterative multiplier.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stall_i,
    input  logic       flush_i,
    ex_stage_if.slave  bus
);

    logic                  w_is_mul;
    logic                  w_mul_busy;
    logic                  w_mul_done;
    logic [63:0]           w_product;
    logic                  w_stallreq;
    logic [4:0]            w_shamt;
    logic [REG_W-1:0]      w_result;

    logic                  r_mem_wreg;
    logic [REG_ADDR_W-1:0] r_mem_wd;
    logic [REG_W-1:0]      r_mem_wdata;
    logic [REG_W-1:0]      r_hi;
    logic [REG_W-1:0]      r_lo;

    assign w_is_mul = (bus.aluop_i == EXE_MULT_OP) || (bus.aluop_i == EXE_MULTU_OP);
    assign w_shamt  = bus.reg1_i[4:0];

    mul_iter u_mul (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_is_mul),
        .i_signed_en (bus.aluop_i == EXE_MULT_OP),
        .i_a         (bus.reg1_i),
        .i_b         (bus.reg2_i),
        .i_stall     (stall_i),
        .i_flush     (flush_i),
        .o_busy      (w_mul_busy),
        .o_done      (w_mul_done),
        .o_product   (w_product)
    );

    // Hold the front end from the cycle a multiply arrives until its DONE cycle.
    assign w_stallreq = w_is_mul & (w_mul_busy | ~w_mul_done);

    // NOTE: the result gets a default before the case so that no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_result = '0;
        case (bus.alusel_i)
            EXE_RES_LOGIC: begin
                case (bus.aluop_i)
                    EXE_OR_OP:  w_result = bus.reg1_i | bus.reg2_i;
                    EXE_AND_OP: w_result = bus.reg1_i & bus.reg2_i;
                    EXE_XOR_OP: w_result = bus.reg1_i ^ bus.reg2_i;
                    EXE_NOR_OP: w_result = ~(bus.reg1_i | bus.reg2_i);
                    default:    w_result = '0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (bus.aluop_i)
                    EXE_SLL_OP: w_result = bus.reg2_i << w_shamt;
                    EXE_SRL_OP: w_result = bus.reg2_i >> w_shamt;
                    EXE_SRA_OP: w_result = $signed(bus.reg2_i) >>> w_shamt;
                    default:    w_result = '0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (bus.aluop_i)
                    EXE_MFHI_OP: w_result = r_hi;
                    EXE_MFLO_OP: w_result = r_lo;
                    default:     w_result = '0;
                endcase
            end
            default: w_result = '0;
        endcase
    end

    assign bus.stallreq_o = w_stallreq;
    assign bus.ex_wd_o    = bus.wd_i;
    assign bus.ex_wdata_o = w_result;
    assign bus.ex_wreg_o  = bus.wreg_i & ~w_stallreq;

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            r_mem_wreg  <= 1'b0;
            r_mem_wd    <= '0;
            r_mem_wdata <= '0;
        end else if (!stall_i) begin
            if (w_stallreq) begin
                r_mem_wreg  <= 1'b0;
                r_mem_wd    <= '0;
                r_mem_wdata <= '0;
            end else begin
                r_mem_wreg  <= bus.ex_wreg_o;
                r_mem_wd    <= bus.ex_wd_o;
                r_mem_wdata <= bus.ex_wdata_o;
            end
        end
    end

    // HI/LO commit on the DONE->IDLE edge; a flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!flush_i && !stall_i && w_mul_done) begin
            r_hi <= w_product[63:32];
            r_lo <= w_product[31:0];
        end
    end

    assign bus.mem_wreg_o  = r_mem_wreg;
    assign bus.mem_wd_o    = r_mem_wd;
    assign bus.mem_wdata_o = r_mem_wdata;
    assign bus.hi_o        = r_hi;
    assign bus.lo_o        = r_lo;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: forward results checked inline, EX/MEM
// writes checked by a scoreboard monitor, multiplier timing checked per op.
module tb_ex_stage;
    import ex_stage_pkg::*;

    typedef struct {
        logic [4:0]  wd;
        logic [31:0] wdata;
    } mem_exp_t;

    logic clk;
    logic rst;
    logic stall_i;
    logic flush_i;

    ex_stage_if bus ();

    ex_stage u_dut (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stall_i),
        .flush_i (flush_i),
        .bus     (bus.slave)
    );

    int       n_checks = 0;
    int       n_pass   = 0;
    mem_exp_t sb_q[$];
    mem_exp_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_nop();
        bus.aluop_i  = EXE_NOP_OP;
        bus.alusel_i = EXE_RES_NOP;
        bus.reg1_i   = '0;
        bus.reg2_i   = '0;
        bus.wd_i     = '0;
        bus.wreg_i   = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        set_nop();
    endtask

    // One single-cycle instruction with wreg=1; expected EX/MEM write queued.
    task automatic issue(input string name, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] wd, input logic [31:0] exp);
        mem_exp_t e;
        @(negedge clk);
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = r1;
        bus.reg2_i   = r2;
        bus.wd_i     = wd;
        bus.wreg_i   = 1'b1;
        #1;
        check({name, "_fwd_data"}, 64'(bus.ex_wdata_o), 64'(exp));
        check({name, "_fwd_wd"},   64'(bus.ex_wd_o),    64'(wd));
        check({name, "_fwd_wreg"}, 64'(bus.ex_wreg_o),  64'd1);
        e.wd    = wd;
        e.wdata = exp;
        sb_q.push_back(e);
    endtask

    // Multiply: counts stallreq cycles, optionally stalls 'hold' cycles in DONE.
    task automatic run_mult(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int hold, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int          stall_cycles = 0;
        bit          mem_quiet    = 1'b1;
        bit          hilo_held    = 1'b1;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        @(negedge clk);
        bus.aluop_i  = op;
        bus.alusel_i = EXE_RES_NOP;
        bus.reg1_i   = a;
        bus.reg2_i   = b;
        bus.wd_i     = '0;
        bus.wreg_i   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!bus.stallreq_o) break;
            stall_cycles++;
            if (i > 0 && bus.mem_wreg_o) mem_quiet = 1'b0;
            @(negedge clk);
        end
        check("mult_stall_cycles", 64'(stall_cycles), 64'd33);
        check("mult_mem_quiet", 64'(mem_quiet), 64'd1);
        old_hi = bus.hi_o;
        old_lo = bus.lo_o;
        if (hold > 0) begin
            stall_i = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                #1;
                if (bus.hi_o !== old_hi || bus.lo_o !== old_lo) hilo_held = 1'b0;
            end
            stall_i = 1'b0;
            check("done_stall_hilo_held", 64'(hilo_held), 64'd1);
        end
        @(negedge clk);
        set_nop();
        #1;
        check("mult_hi", 64'(bus.hi_o), 64'(exp_hi));
        check("mult_lo", 64'(bus.lo_o), 64'(exp_lo));
    endtask

    // Scoreboard monitor: every EX/MEM write must match the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst && bus.mem_wreg_o) begin
                if (sb_q.size() == 0) begin
                    check("mem_unexpected_write", 64'(bus.mem_wreg_o), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("mem_wd",    64'(bus.mem_wd_o),    64'(mon_e.wd));
                    check("mem_wdata", 64'(bus.mem_wdata_o), 64'(mon_e.wdata));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        set_nop();
        repeat (2) @(negedge clk);
        #1;
        check("rst_hi",        64'(bus.hi_o),        64'd0);
        check("rst_lo",        64'(bus.lo_o),        64'd0);
        check("rst_mem_wreg",  64'(bus.mem_wreg_o),  64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata_o), 64'd0);
        check("rst_stallreq",  64'(bus.stallreq_o),  64'd0);
        rst = 1'b1;

        issue("or",   EXE_OR_OP,  EXE_RES_LOGIC, 32'h0F0F0000, 32'h0000FFFF, 5'd5,  32'h0F0FFFFF);
        issue("sra",  EXE_SRA_OP, EXE_RES_SHIFT, 32'd4,        32'h80000000, 5'd6,  32'hF8000000);
        issue("srl",  EXE_SRL_OP, EXE_RES_SHIFT, 32'd4,        32'h80000000, 5'd7,  32'h08000000);
        issue("nor",  EXE_NOR_OP, EXE_RES_LOGIC, 32'd0,        32'd0,        5'd8,  32'hFFFFFFFF);
        issue("and",  EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0F0F0, 32'hFF00FF00, 5'd9,  32'hF000F000);
        issue("xor",  EXE_XOR_OP, EXE_RES_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 5'd10, 32'hF0F00F0F);
        issue("sll",  EXE_SLL_OP, EXE_RES_SHIFT, 32'd8,        32'h000000AB, 5'd11, 32'h0000AB00);
        issue("badop",  8'hFF,    EXE_RES_LOGIC, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'h00000000);
        issue("badsel", EXE_OR_OP, 3'b111,       32'hFFFFFFFF, 32'h12345678, 5'd13, 32'h00000000);
        idle();

        // Signed -3 x 7 = -21, then read back through MFLO/MFHI.
        run_mult(EXE_MULT_OP, 32'hFFFFFFFD, 32'd7, 0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        issue("mflo", EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd3, 32'hFFFFFFEB);
        issue("mfhi", EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd4, 32'hFFFFFFFF);
        idle();

        // Unsigned max x max with a 3-cycle stall in DONE.
        run_mult(EXE_MULTU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 32'hFFFFFFFE, 32'h00000001);

        // Flush at BUSY cnt=10: multiply abandoned, HI/LO untouched.
        @(negedge clk);
        bus.aluop_i  = EXE_MULT_OP;
        bus.alusel_i = EXE_RES_NOP;
        bus.reg1_i   = 32'd5;
        bus.reg2_i   = 32'd6;
        repeat (11) @(negedge clk);
        #1;
        check("flush_pre_stallreq", 64'(bus.stallreq_o), 64'd1);
        flush_i = 1'b1;
        set_nop();
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        check("flush_stallreq", 64'(bus.stallreq_o), 64'd0);
        check("flush_hi",       64'(bus.hi_o),       64'hFFFFFFFE);
        check("flush_lo",       64'(bus.lo_o),       64'h00000001);
        check("flush_mem_wreg", 64'(bus.mem_wreg_o), 64'd0);
        run_mult(EXE_MULT_OP, 32'd5, 32'd6, 0, 32'd0, 32'd30);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.aluop_i = EXE_MULTU_OP;
        bus.reg1_i  = 32'd7;
        bus.reg2_i  = 32'd9;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        set_nop();
        @(negedge clk);
        #1;
        check("midrst_hi",        64'(bus.hi_o),        64'd0);
        check("midrst_lo",        64'(bus.lo_o),        64'd0);
        check("midrst_mem_wreg",  64'(bus.mem_wreg_o),  64'd0);
        check("midrst_mem_wd",    64'(bus.mem_wd_o),    64'd0);
        check("midrst_mem_wdata", 64'(bus.mem_wdata_o), 64'd0);
        check("midrst_stallreq",  64'(bus.stallreq_o),  64'd0);
        rst = 1'b1;

        // Most-negative operand: -2^31 x 2 = -2^32.
        run_mult(EXE_MULT_OP, 32'h80000000, 32'd2, 0, 32'hFFFFFFFF, 32'h00000000);

        repeat (3) idle();
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
